// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and constants for the digit-serial add/subtract
//               datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    // Default digit width. Modules built with another width redefine digit_t.
    localparam int DIGIT_W_DEF = 1;
    typedef logic [DIGIT_W_DEF-1:0] digit_t;

    // Operation mode, latched on the first beat of each word
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Word-tracking FSM: IDLE waits for a first beat, ACTIVE is mid-word
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } word_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_digit_add.sv
// ============================================================================
// Module      : serial_digit_add
// Description : Combinational W-bit adder with carry-in. Also reports the
//               carry into the MSB so the caller can form signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_digit_add #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s        = w_full[W-1:0];
    assign cout     = w_full[W];
    // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out
    // of the sum bit XORed with the operand MSBs. Works for W == 1 too.
    assign c_msb_in = w_full[W-1] ^ a[W-1] ^ b[W-1];

endmodule

`default_nettype wire

// File: rtl/serial_addsub_with_vld.sv
// ============================================================================
// Module      : serial_addsub_with_vld
// Description : Digit-serial two's-complement adder/subtractor. Operands
//               arrive LSB digit first; results leave one cycle later with
//               valid/last, carry-out and signed overflow on the last digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_with_vld
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    input  logic               sub,
    output logic               sum_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               sum_last,
    output logic               carry_out,
    output logic               overflow,
    output logic               busy
);

    typedef logic [DIGIT_W-1:0] digit_t;

    word_state_t state_q, state_d;
    logic        carry_q, carry_d;
    logic        mode_q, mode_d;
    digit_t      sum_q, sum_d;
    logic        sum_vld_q, sum_vld_d;
    logic        sum_last_q, sum_last_d;
    logic        carry_out_q, carry_out_d;
    logic        overflow_q, overflow_d;

    logic        w_in_word;
    logic        w_mode;
    digit_t      w_b_eff;
    logic        w_cin;
    digit_t      w_s;
    logic        w_cout;
    logic        w_c_msb_in;

    assign w_in_word = (state_q == ST_ACTIVE);

    // First beat uses the live sub input; later beats use the latched mode.
    // Subtraction is A + ~B + 1, with the +1 entering as the initial carry.
    assign w_mode  = w_in_word ? mode_q : sub;
    assign w_b_eff = (w_mode == MODE_SUB) ? ~b : b;
    assign w_cin   = w_in_word ? carry_q : w_mode;

    serial_digit_add #(
        .W (DIGIT_W)
    ) u_digit_add (
        .a        (a),
        .b        (w_b_eff),
        .cin      (w_cin),
        .s        (w_s),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Next-state and output-register computation; inputs only matter when vld
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        sum_d       = sum_q;
        sum_vld_d   = 1'b0;
        sum_last_d  = 1'b0;
        carry_out_d = 1'b0;
        overflow_d  = 1'b0;

        if (vld) begin
            sum_d      = w_s;
            sum_vld_d  = 1'b1;
            sum_last_d = last;
            if (!w_in_word) begin
                mode_d = sub;
            end
            if (last) begin
                carry_out_d = w_cout;
                overflow_d  = w_cout ^ w_c_msb_in;
                carry_d     = 1'b0;
                state_d     = ST_IDLE;
            end else begin
                carry_d     = w_cout;
                state_d     = ST_ACTIVE;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            carry_q     <= 1'b0;
            mode_q      <= MODE_ADD;
            sum_q       <= '0;
            sum_vld_q   <= 1'b0;
            sum_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
            sum_q       <= sum_d;
            sum_vld_q   <= sum_vld_d;
            sum_last_q  <= sum_last_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sum_vld   = sum_vld_q;
    assign sum       = sum_q;
    assign sum_last  = sum_last_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = w_in_word;

endmodule

`default_nettype wire
